// File: rtl/sm_serial_subtractor.sv
// ============================================================================
//  Module      : sm_serial_subtractor
//  Description : Multi-cycle sign-magnitude subtractor, out = a - b.
//                Magnitudes are combined bit-serially (LSB first) with a
//                single full adder/subtractor and a carry/borrow flop.
//                Valid/ready handshake on operand and result sides.
//  Options     : SM_SUB_SAT_EN - saturate the magnitude on overflow instead
//                of wrapping it modulo 2^(SIZE-1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_serial_subtractor #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out,
    output logic            ovf
);

    localparam int              c_MW   = SIZE - 1;
    localparam int              c_CW   = $clog2(SIZE);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(SIZE - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMP   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [SIZE-1:0]   r_a;        // latched minuend
    logic [SIZE-1:0]   r_b;        // latched subtrahend with sign flipped
    logic [c_MW-1:0]   r_max;      // larger magnitude; result shifts in at MSB
    logic [c_MW-1:0]   r_min;      // smaller magnitude
    logic              r_sign;
    logic              r_op_add;
    logic              r_cy;       // carry (add) or borrow (subtract)
    logic [c_CW-1:0]   r_cnt;
    logic [SIZE-1:0]   r_out;
    logic              r_ovf;

    logic [c_MW-1:0]   w_mag_a;
    logic [c_MW-1:0]   w_mag_b;
    logic              w_x;
    logic              w_y;
    logic              w_bit;
    logic              w_cy_next;
    logic [c_MW-1:0]   w_mag_res;
    logic [c_MW-1:0]   w_mag_fin;
    logic              w_ovf;
    logic              w_sign_fin;

    assign out = r_out;
    assign ovf = r_ovf;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_CMP;
                end
            end
            S_CMP: begin
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == c_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // One serial bit step plus final result shaping
    always_comb begin
        w_mag_a   = r_a[c_MW-1:0];
        w_mag_b   = r_b[c_MW-1:0];
        w_x       = r_max[0];
        w_y       = r_min[0];
        w_bit     = w_x ^ w_y ^ r_cy;
        if (r_op_add) begin
            w_cy_next = (w_x & w_y) | (w_x & r_cy) | (w_y & r_cy);
        end else begin
            w_cy_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_cy);
        end
        w_mag_res = {w_bit, r_max[c_MW-1:1]};
        // Subtraction of a smaller magnitude from a larger one cannot overflow
        w_ovf     = r_op_add & w_cy_next;
`ifdef SM_SUB_SAT_EN
        w_mag_fin = w_ovf ? {c_MW{1'b1}} : w_mag_res;
`else
        w_mag_fin = w_mag_res;
`endif
        // Never emit negative zero
        w_sign_fin = (w_mag_fin == '0) ? 1'b0 : r_sign;
    end

    // Operand capture, serial datapath and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_max    <= '0;
            r_min    <= '0;
            r_sign   <= 1'b0;
            r_op_add <= 1'b0;
            r_cy     <= 1'b0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= a;
                        r_b <= {~b[SIZE-1], b[SIZE-2:0]};
                    end
                end
                S_CMP: begin
                    if (w_mag_a > w_mag_b) begin
                        r_max  <= w_mag_a;
                        r_min  <= w_mag_b;
                        r_sign <= r_a[SIZE-1];
                    end else begin
                        r_max  <= w_mag_b;
                        r_min  <= w_mag_a;
                        r_sign <= r_b[SIZE-1];
                    end
                    r_op_add <= (r_a[SIZE-1] == r_b[SIZE-1]);
                    r_cy     <= 1'b0;
                    r_cnt    <= '0;
                end
                S_SHIFT: begin
                    r_max <= w_mag_res;
                    r_min <= r_min >> 1;
                    r_cy  <= w_cy_next;
                    r_cnt <= r_cnt + c_CW'(1);
                    if (r_cnt == c_LAST) begin
                        r_out <= {w_sign_fin, w_mag_fin};
                        r_ovf <= w_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sm_serial_subtractor.sv
// ============================================================================
//  Module      : tb_sm_serial_subtractor
//  Description : Scoreboard bench for sm_serial_subtractor with an integer
//                reference model, directed corner cases, backpressure,
//                mid-operation reset and random operands.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_serial_subtractor;

    localparam int SIZE = 16;
    localparam int MW   = SIZE - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out;
    logic            ovf;

    always #5 clk = ~clk;

    sm_serial_subtractor #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf)
    );

    typedef struct {
        logic [SIZE-1:0] out;
        logic            ovf;
        int              acc;
    } exp_t;

    exp_t            sbq[$];
    int              total = 0;
    int              bad   = 0;
    int              cyc   = 0;

    logic            mon_en     = 1'b0;
    logic            prev_valid = 1'b0;
    logic            popped     = 1'b0;
    logic            bp_pulse   = 1'b0;
    int              bp_left    = 0;
    logic [SIZE-1:0] last_out   = '0;
    logic            last_ovf   = 1'b0;
    logic [SIZE-1:0] held_out   = '0;
    logic            held_ovf   = 1'b0;

    // Edge counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: signed integer arithmetic on the decoded operands
    function automatic exp_t model(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
        exp_t e;
        int   va;
        int   vb;
        int   d;
        int   m;
        va = x[SIZE-1] ? -int'(x[MW-1:0]) : int'(x[MW-1:0]);
        vb = y[SIZE-1] ? -int'(y[MW-1:0]) : int'(y[MW-1:0]);
        d  = va - vb;
        m  = (d < 0) ? -d : d;
        e.ovf = (m >= (1 << MW));
`ifdef SM_SUB_SAT_EN
        if (e.ovf) m = (1 << MW) - 1;
`else
        m = m % (1 << MW);
`endif
        e.out = {(d < 0) && (m != 0), MW'(m)};
        e.acc = 0;
        return e;
    endfunction

    task automatic send(input logic [SIZE-1:0] xa, input logic [SIZE-1:0] xb,
                        input logic [SIZE-1:0] eo, input logic eovf);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        sbq.push_back('{eo, eovf, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
        a        = SIZE'($urandom);
        b        = SIZE'($urandom);
    endtask

    task automatic send_m(input logic [SIZE-1:0] xa, input logic [SIZE-1:0] xb);
        exp_t e;
        e = model(xa, xb);
        send(xa, xb, e.out, e.ovf);
    endtask

    // Monitor: drives out_ready, checks results, latency, stability, idle hold
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            if (out_valid) begin
                if (!prev_valid) begin
                    if (sbq.size() > 0) chk("latency", cyc - sbq[0].acc, SIZE);
                end else begin
                    chk("stable_out", out, held_out);
                    chk("stable_ovf", ovf, held_ovf);
                end
                chk("in_ready_done", in_ready, 1'b0);
                held_out = out;
                held_ovf = ovf;
                if (bp_left > 0) begin
                    out_ready = 1'b0;
                    bp_left--;
                    bp_pulse = (bp_left == 0);
                end else if (bp_pulse) begin
                    out_ready = 1'b1;
                    bp_pulse  = 1'b0;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                popped = 1'b0;
                if (out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("out", out, e.out);
                        chk("ovf", ovf, e.ovf);
                        last_out = e.out;
                        last_ovf = e.ovf;
                        popped   = 1'b1;
                    end
                end
                prev_valid = !out_ready;
            end else begin
                if (popped) chk("in_ready_after_pop", in_ready, 1'b1);
                popped = 1'b0;
                chk("hold_out", out, last_out);
                chk("hold_ovf", ovf, last_ovf);
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        logic [SIZE-1:0] ra;
        logic [SIZE-1:0] rb;
        int              n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out", out, 16'h0000);
        chk("rst_ovf", ovf, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;

        send(16'h0005, 16'h0003, 16'h0002, 1'b0);
        send(16'h0003, 16'h0005, 16'h8002, 1'b0);
        send(16'h8004, 16'h0003, 16'h8007, 1'b0);
        send(16'h0005, 16'h0005, 16'h0000, 1'b0);
        send(16'h8005, 16'h8005, 16'h0000, 1'b0);
`ifdef SM_SUB_SAT_EN
        send(16'h7FFF, 16'h8001, 16'h7FFF, 1'b1);
        send(16'hFFFF, 16'h0001, 16'hFFFF, 1'b1);
`else
        send(16'h7FFF, 16'h8001, 16'h0000, 1'b1);
        send(16'hFFFF, 16'h0001, 16'h0000, 1'b1);
`endif
        send(16'h8000, 16'h0003, 16'h8003, 1'b0);

        // Backpressure: five held cycles then a single accept pulse
        bp_left = 5;
        send(16'h1234, 16'h0234, 16'h1000, 1'b0);

        // Reset during the eighth serial step discards the operation
        send(16'h0100, 16'h0001, 16'h00FF, 1'b0);
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out", out, 16'h0000);
        chk("midrst_ovf", ovf, 1'b0);
        sbq.delete();
        last_out   = '0;
        last_ovf   = 1'b0;
        prev_valid = 1'b0;
        popped     = 1'b0;
        bp_left    = 0;
        bp_pulse   = 1'b0;
        mon_en     = 1'b1;
        send(16'h0100, 16'h0001, 16'h00FF, 1'b0);

        // Random operands, biased sometimes toward large magnitudes
        for (int i = 0; i < 40; i++) begin
            ra = SIZE'($urandom);
            rb = SIZE'($urandom);
            if ($urandom_range(0, 3) == 0) ra[MW-1:MW-3] = 3'b111;
            if ($urandom_range(0, 3) == 0) rb[MW-1:MW-3] = 3'b111;
            if ($urandom_range(0, 7) == 0) rb = ra;
            send_m(ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while (sbq.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) chk("drain_timeout", sbq.size(), 0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
